// File: rtl/cache.sv
// Set-associative write-back, write-allocate cache in front of an internal word-addressed backing memory.
// Replacement is FIFO per set by default; defining CACHE_LRU_EN selects per-way age LRU instead.
module cache #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 1,
   parameter int TAG_ADDR_LEN  = 7,
   parameter int WAY_CNT       = 2,
   parameter int MEM_LATENCY   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        rd_req,
   input  logic        wr_req,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        miss
);
   localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;
   localparam int SETS       = 1 << SET_ADDR_LEN;
   localparam int MEM_AW     = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN;
   localparam int MEM_WORDS  = 1 << MEM_AW;
   localparam int WAY_W      = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
   localparam int CNT_W      = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
   // The line read is launched in the cycle the fill is decided, so SWAP_IN shows the remaining cycles.
   localparam state_t READ_FIRST = (MEM_LATENCY > 1) ? SWAP_IN : SWAP_IN_OK;

   logic [LINE_ADDR_LEN-1:0] word_idx;
   logic [SET_ADDR_LEN-1:0]  set_idx;
   logic [TAG_ADDR_LEN-1:0]  tag_in;
   logic                     addr_unused;
   assign word_idx    = addr[LINE_ADDR_LEN+1:2];
   assign set_idx     = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
   assign tag_in      = addr[LINE_ADDR_LEN+SET_ADDR_LEN+2 +: TAG_ADDR_LEN];
   assign addr_unused = ^{addr[1:0], addr[31:MEM_AW+2]};

   logic [31:0]             mem      [MEM_WORDS];
   logic [31:0]             line_ram [SETS][WAY_CNT][LINE_WORDS];
   logic [TAG_ADDR_LEN-1:0] tag_ram  [SETS][WAY_CNT];

   logic [WAY_CNT-1:0] valid_q [SETS], valid_d [SETS];
   logic [WAY_CNT-1:0] dirty_q [SETS], dirty_d [SETS];
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WAY_W-1:0]   victim_q, victim_d;
   logic [31:0]        rd_data_q, rd_data_d;

   logic [WAY_CNT-1:0] way_hit;
   logic               hit, inv_found, wr_hit_en, fill_en, wb_en, touch_en;
   logic [WAY_W-1:0]   hit_way, victim, repl_victim, touch_way;

   for (genvar gi = 0; gi < WAY_CNT; gi++) begin : g_tag_cmp
      assign way_hit[gi] = valid_q[set_idx][gi] && (tag_ram[set_idx][gi] == tag_in);
   end

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      victim    = '0;
      for (int w = WAY_CNT - 1; w >= 0; w--) begin
         if (way_hit[w]) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[set_idx][w]) begin
            inv_found = 1'b1;
            victim    = WAY_W'(w);
         end
      end
      if (!inv_found) victim = repl_victim;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      victim_d  = victim_q;
      rd_data_d = rd_data_q;
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      wr_hit_en = 1'b0;
      fill_en   = 1'b0;
      wb_en     = 1'b0;
      touch_en  = 1'b0;
      touch_way = hit_way;
      case (state_q)
         IDLE: if (rd_req || wr_req) begin
            if (hit) begin
               touch_en = 1'b1;
               if (wr_req) begin
                  wr_hit_en                 = 1'b1;
                  dirty_d[set_idx][hit_way] = 1'b1;
               end else begin
                  rd_data_d = line_ram[set_idx][hit_way][word_idx];
               end
            end else begin
               victim_d = victim;
               if (valid_q[set_idx][victim] && dirty_q[set_idx][victim]) begin
                  state_d = SWAP_OUT;
                  cnt_d   = '0;
               end else begin
                  state_d = READ_FIRST;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         SWAP_OUT: begin
            if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
               wb_en   = 1'b1;
               state_d = READ_FIRST;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SWAP_IN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(MEM_LATENCY)) state_d = SWAP_IN_OK;
         end
         SWAP_IN_OK: begin
            fill_en                    = 1'b1;
            valid_d[set_idx][victim_q] = 1'b1;
            dirty_d[set_idx][victim_q] = 1'b0;
            touch_en                   = 1'b1;
            touch_way                  = victim_q;
            state_d                    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef CACHE_LRU_EN
   logic [WAY_W-1:0] age_q [SETS][WAY_CNT], age_d [SETS][WAY_CNT];

   always_comb begin
      repl_victim = '0;
      for (int w = 1; w < WAY_CNT; w++)
         if (age_q[set_idx][w] > age_q[set_idx][repl_victim]) repl_victim = WAY_W'(w);
   end

   always_comb begin
      age_d = age_q;
      if (touch_en) begin
         for (int w = 0; w < WAY_CNT; w++) begin
            if (WAY_W'(w) == touch_way) age_d[set_idx][w] = '0;
            else if (age_q[set_idx][w] != '1) age_d[set_idx][w] = age_q[set_idx][w] + 1'b1;
         end
      end
   end
`else
   logic [WAY_W-1:0] ptr_q [SETS], ptr_d [SETS];
   logic             touch_unused;
   assign repl_victim  = ptr_q[set_idx];
   assign touch_unused = touch_en ^ (^touch_way);

   always_comb begin
      ptr_d = ptr_q;
      if (fill_en)
         ptr_d[set_idx] = (ptr_q[set_idx] == WAY_W'(WAY_CNT - 1)) ? '0 : ptr_q[set_idx] + 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         victim_q  <= '0;
         rd_data_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
`ifdef CACHE_LRU_EN
            for (int w = 0; w < WAY_CNT; w++) age_q[s][w] <= '0;
`else
            ptr_q[s] <= '0;
`endif
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         victim_q  <= victim_d;
         rd_data_q <= rd_data_d;
         valid_q   <= valid_d;
         dirty_q   <= dirty_d;
`ifdef CACHE_LRU_EN
         age_q     <= age_d;
`else
         ptr_q     <= ptr_d;
`endif
      end
   end

   // Line storage and backing memory carry no reset; only the control state above is cleared.
   always_ff @(posedge clk) begin
      if (wr_hit_en) line_ram[set_idx][hit_way][word_idx] <= wr_data;
      if (fill_en) begin
         tag_ram[set_idx][victim_q] <= tag_in;
         for (int w = 0; w < LINE_WORDS; w++)
            line_ram[set_idx][victim_q][LINE_ADDR_LEN'(w)] <= mem[{tag_in, set_idx, LINE_ADDR_LEN'(w)}];
      end
   end

   always_ff @(posedge clk) begin
      if (wb_en) begin
         for (int w = 0; w < LINE_WORDS; w++)
            mem[{tag_ram[set_idx][victim_q], set_idx, LINE_ADDR_LEN'(w)}] <= line_ram[set_idx][victim_q][LINE_ADDR_LEN'(w)];
      end
   end

   assign rd_data = rd_data_q;
   assign miss    = rst & ((state_q != IDLE) | ((rd_req | wr_req) & ~hit));
endmodule

// File: tb/tb_cache.sv
// Randomised scoreboard bench for cache: a word-level reference model predicts read data and miss
// latency per request; a monitor process compares them as the DUT accepts each request.
module tb_cache;
   localparam int LINE   = 3;
   localparam int SETB   = 1;
   localparam int TAGB   = 7;
   localparam int WAYS   = 2;
   localparam int LAT    = 8;
   localparam int NSETS  = 1 << SETB;
   localparam int NWORDS = 1 << LINE;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic        rd_req = 1'b0;
   logic        wr_req = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        miss;

   cache #(.LINE_ADDR_LEN(LINE), .SET_ADDR_LEN(SETB), .TAG_ADDR_LEN(TAGB),
           .WAY_CNT(WAYS), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .addr(addr), .rd_req(rd_req), .wr_req(wr_req),
      .wr_data(wr_data), .rd_data(rd_data), .miss(miss));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int          lat_q[$];
   logic [31:0] dat_q[$];

   typedef struct {
      bit                         v;
      bit                         d;
      bit [TAGB-1:0]              tag;
      bit [NWORDS-1:0][31:0]      w;
      int                         stamp;
   } line_t;

   line_t     c_m    [NSETS][WAYS];
   bit [31:0] mem_m  [1 << (TAGB + SETB + LINE)];
   int        fills_m[NSETS];
   int        tick = 0;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < NSETS; s++) begin
         fills_m[s] = 0;
         for (int i = 0; i < WAYS; i++) begin
            c_m[s][i].v     = 1'b0;
            c_m[s][i].d     = 1'b0;
            c_m[s][i].stamp = 0;
         end
      end
   endfunction

   function automatic int mem_index(input int t, input int s, input int i);
      return (t << (SETB + LINE)) | (s << LINE) | i;
   endfunction

   // Reference: hit -> 0 cycles; clean fill -> LAT+1; dirty eviction -> 2*LAT+1.
   function automatic void model_access(input logic [31:0] a, input bit is_wr, input logic [31:0] wd,
                                        output int lat, output logic [31:0] rv);
      int s, t, wi, h;
      s   = int'(a[LINE+2 +: SETB]);
      t   = int'(a[LINE+SETB+2 +: TAGB]);
      wi  = int'(a[LINE+1:2]);
      h   = -1;
      lat = 0;
      rv  = '0;
      for (int i = 0; i < WAYS; i++)
         if (h < 0 && c_m[s][i].v && int'(c_m[s][i].tag) == t) h = i;
      if (h < 0) begin
         for (int i = 0; i < WAYS; i++)
            if (h < 0 && !c_m[s][i].v) h = i;
         if (h < 0) begin
`ifdef CACHE_LRU_EN
            h = 0;
            for (int i = 1; i < WAYS; i++)
               if (c_m[s][i].stamp < c_m[s][h].stamp) h = i;
`else
            h = fills_m[s] % WAYS;
`endif
         end
         if (c_m[s][h].v && c_m[s][h].d) begin
            for (int i = 0; i < NWORDS; i++)
               mem_m[mem_index(int'(c_m[s][h].tag), s, i)] = c_m[s][h].w[i];
            lat = 2 * LAT + 1;
         end else begin
            lat = LAT + 1;
         end
         for (int i = 0; i < NWORDS; i++) c_m[s][h].w[i] = mem_m[mem_index(t, s, i)];
         c_m[s][h].v   = 1'b1;
         c_m[s][h].d   = 1'b0;
         c_m[s][h].tag = TAGB'(t);
         fills_m[s]++;
      end
      tick++;
      c_m[s][h].stamp = tick;
      if (is_wr) begin
         c_m[s][h].w[wi] = wd;
         c_m[s][h].d     = 1'b1;
      end else begin
         rv = c_m[s][h].w[wi];
      end
   endfunction

   task automatic wait_accept(input logic [31:0] a);
      bit done = 1'b0;
      for (int i = 0; i < 4 * LAT + 10 && !done; i++) begin
         @(negedge clk);
         if (!miss) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL stall_bound addr=%h miss still high after budget", a);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic [31:0] a, input bit r, input bit w, input logic [31:0] d);
      int          lat;
      logic [31:0] rv;
      model_access(a, w, d, lat, rv);
      lat_q.push_back(lat);
      if (r && !w) dat_q.push_back(rv);
      addr    = a;
      rd_req  = r;
      wr_req  = w;
      wr_data = d;
      wait_accept(a);
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      addr   = '0;
      rd_req = 1'b1;
      #1;
      check("reset_miss", 32'(miss), 32'd0);
      check("reset_rd_data", rd_data, 32'd0);
      repeat (cycles) @(posedge clk);
      #1;
      rd_req = 1'b0;
      rst    = 1'b1;
      model_reset();
   endtask

   // Monitor: pops expectations when the DUT accepts a request (request high, miss low).
   initial begin
      int          miss_cnt = 0;
      bit          rd_pend  = 1'b0;
      logic [31:0] last_rd  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            miss_cnt = 0;
            rd_pend  = 1'b0;
            last_rd  = '0;
         end else begin
            if (rd_pend) begin
               rd_pend = 1'b0;
               if (dat_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL read_data_unexpected got=%h want=none", rd_data);
               end else begin
                  last_rd = dat_q.pop_front();
               end
            end
            check("rd_data", rd_data, last_rd);
            if (rd_req || wr_req) begin
               if (miss) begin
                  miss_cnt++;
               end else begin
                  if (lat_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL accept_unexpected addr=%h", addr);
                  end else begin
                     check("miss_cycles", 32'(miss_cnt), 32'(lat_q.pop_front()));
                  end
                  miss_cnt = 0;
                  if (rd_req && !wr_req) rd_pend = 1'b1;
               end
            end else begin
               check("idle_miss", 32'(miss), 32'd0);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          k, lat;
      logic [31:0] rv;
      mem_m = '{default: '0};
      model_reset();
      #1;
      rst    = 1'b0;
      rd_req = 1'b1;
      #2;
      check("por_miss", 32'(miss), 32'd0);
      check("por_rd_data", rd_data, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rd_req = 1'b0;
      rst    = 1'b1;

      txn(32'h000, 1'b1, 1'b0, '0);
      txn(32'h004, 1'b0, 1'b1, 32'h1234_5678);
      txn(32'h007, 1'b1, 1'b0, '0);
      txn(32'h000, 1'b0, 1'b1, 32'h0000_000A);
      txn(32'h040, 1'b0, 1'b1, 32'h0000_000B);
      txn(32'h080, 1'b1, 1'b0, '0);
      txn(32'h000, 1'b1, 1'b0, '0);
      txn(32'h020, 1'b0, 1'b1, 32'hCAFE_0020);
      txn(32'h000, 1'b1, 1'b0, '0);
      txn(32'h024, 1'b1, 1'b1, 32'h5555_AAAA);
      txn(32'h024, 1'b1, 1'b0, '0);

      do_reset(2);
      txn(32'h000, 1'b1, 1'b0, '0);
      txn(32'h040, 1'b1, 1'b0, '0);
      txn(32'h000, 1'b1, 1'b0, '0);
      txn(32'h080, 1'b1, 1'b0, '0);
      txn(32'h040, 1'b1, 1'b0, '0);
      txn(32'h000, 1'b1, 1'b0, '0);

      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         a[LINE+SETB+2 +: TAGB] = TAGB'($urandom_range(0, 3));
         k = $urandom_range(0, 3);
         txn(a, k != 2, k >= 2, $urandom);
         k = $urandom_range(0, 2);
         for (int g = 0; g < k; g++) begin
            @(posedge clk);
            #1;
         end
      end

      do_reset(2);
      addr   = 32'h0000_0044;
      rd_req = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("swap_in_reset_miss", 32'(miss), 32'd0);
      check("swap_in_reset_rd_data", rd_data, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      model_access(addr, 1'b0, '0, lat, rv);
      lat_q.push_back(lat);
      dat_q.push_back(rv);
      rst = 1'b1;
      wait_accept(addr);
      rd_req = 1'b0;
      txn(32'h0000_0040, 1'b1, 1'b0, '0);

      repeat (3) @(negedge clk);
      check("queues_drained", 32'(lat_q.size() + dat_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
